// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/redirect control in, ROM address/data, IF/ID register out.
interface fetch_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              stall;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_instr;
  logic              if_valid;
  logic [31:0]       if_pc;
  logic [31:0]       if_instr;
  logic              halted;

  // Environment side: hazard unit, branch resolution, ROM and decode.
  modport master (
    output stall, redirect_valid, redirect_pc, rom_instr,
    input  rom_addr, if_valid, if_pc, if_instr, halted
  );

  // Fetch stage side.
  modport slave (
    input  stall, redirect_valid, redirect_pc, rom_instr,
    output rom_addr, if_valid, if_pc, if_instr, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, addresses the ROM and fills the IF/ID register.
// Handles stall, redirect (flush) and stops on the halt encoding until redirected.
module fetch_stage #(
  parameter int unsigned ADDR_W    = 5,
  parameter logic [31:0] NOP_INSN  = 32'h0000_0013,
  parameter logic [31:0] HALT_INSN = 32'hFFFF_FFFF
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.slave bus
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= 32'd0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'd0;
      if_instr_q <= NOP_INSN;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  // Priority: redirect beats stall beats normal fetch; hold is the default.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    if (bus.redirect_valid) begin
      // Wrong-path word (including a halt) is dropped; low target bits ignored.
      state_d    = RUN;
      pc_d       = bus.redirect_pc & ~32'd3;
      if_valid_d = 1'b0;
      if_pc_d    = 32'd0;
      if_instr_d = NOP_INSN;
    end else if (!bus.stall) begin
      case (state_q)
        RUN: begin
          if_valid_d = 1'b1;
          if_pc_d    = pc_q;
          if_instr_d = bus.rom_instr;
          if (bus.rom_instr == HALT_INSN) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
        HALTED: begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign bus.rom_addr = pc_q[ADDR_W+1:2];
  assign bus.if_valid = if_valid_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_instr = if_instr_q;
  assign bus.halted   = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, free-run, stall, redirect, halt and wrap.
module tb_fetch_stage;

  localparam int unsigned ADDR_W = 5;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] HALT   = 32'hFFFF_FFFF;

  logic clk;
  logic rst;
  logic [31:0] rom [0:31];
  int errors;
  int checks;

  fetch_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_stage #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.rom_instr = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_if(input string tag, input logic [31:0] a, input logic v,
                          input logic [31:0] pc, input logic [31:0] ins, input logic h);
    check({tag, ".rom_addr"}, 32'(bus.rom_addr), a);
    check({tag, ".if_valid"}, 32'(bus.if_valid), 32'(v));
    check({tag, ".if_pc"},    bus.if_pc, pc);
    check({tag, ".if_instr"}, bus.if_instr, ins);
    check({tag, ".halted"},   32'(bus.halted), 32'(h));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 32; i++) rom[i] = NOP;
    rom[0]  = 32'h0080_0293;
    rom[1]  = 32'h00F0_0313;
    rom[24] = HALT;

    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;

    tick();
    check_if("reset", 32'd0, 1'b0, 32'd0, NOP, 1'b0);

    // Free run from 0
    rst = 1'b0;
    tick();
    check_if("run_e1", 32'd1, 1'b1, 32'h0, 32'h0080_0293, 1'b0);
    tick();
    check_if("run_e2", 32'd2, 1'b1, 32'h4, 32'h00F0_0313, 1'b0);
    tick();
    check_if("run_e3", 32'd3, 1'b1, 32'h8, NOP, 1'b0);
    tick();
    check_if("run_e4", 32'd4, 1'b1, 32'hC, NOP, 1'b0);

    // Stall three cycles with pc=0x10
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_if("stall_hold", 32'd4, 1'b1, 32'hC, NOP, 1'b0);
    end
    bus.stall = 1'b0;
    tick();
    check_if("stall_resume1", 32'd5, 1'b1, 32'h10, NOP, 1'b0);
    tick();
    check_if("stall_resume2", 32'd6, 1'b1, 32'h14, NOP, 1'b0);

    // Run up to just before the halt word at 0x60
    for (int i = 0; i < 18; i++) tick();
    check_if("pre_halt", 32'd24, 1'b1, 32'h5C, NOP, 1'b0);
    tick();
    check_if("halt_capture", 32'd24, 1'b1, 32'h60, HALT, 1'b1);
    tick();
    check_if("halted_1", 32'd24, 1'b0, 32'h60, NOP, 1'b1);
    tick();
    check_if("halted_2", 32'd24, 1'b0, 32'h60, NOP, 1'b1);

    // Redirect out of HALTED to 0x04
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h4;
    tick();
    check_if("redir_halt", 32'd1, 1'b0, 32'h0, NOP, 1'b0);
    bus.redirect_valid = 1'b0;
    tick();
    check_if("redir_halt_f", 32'd2, 1'b1, 32'h4, 32'h00F0_0313, 1'b0);

    // Redirect with simultaneous stall at pc=0x08, misaligned target
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h2E;
    bus.stall = 1'b1;
    tick();
    check_if("redir_stall", 32'd11, 1'b0, 32'h0, NOP, 1'b0);
    bus.redirect_valid = 1'b0;
    bus.stall = 1'b0;
    tick();
    check_if("redir_stall_f", 32'd12, 1'b1, 32'h2C, NOP, 1'b0);
    tick();
    check_if("pre_reset", 32'd13, 1'b1, 32'h30, NOP, 1'b0);

    // Reset mid-run with pc=0x34
    rst = 1'b1;
    tick();
    check_if("mid_reset", 32'd0, 1'b0, 32'h0, NOP, 1'b0);
    rst = 1'b0;

    // Wrap of the ROM word address past the top
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h7C;
    tick();
    check_if("wrap_redir", 32'd31, 1'b0, 32'h0, NOP, 1'b0);
    bus.redirect_valid = 1'b0;
    tick();
    check_if("wrap_e1", 32'd0, 1'b1, 32'h7C, NOP, 1'b0);
    tick();
    check_if("wrap_e2", 32'd1, 1'b1, 32'h80, 32'h0080_0293, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
